// File: rtl/enh_pkg.sv
// Shared constants and helpers for the tagged-stream merge/split tree.
package enh_pkg;

  // Branch preference; LEFT names out_1, RIGHT names out_2.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } pref_t;

  // Payload width of a tagged word once the validity bits are stripped.
  function automatic int payload_width(input int word_width, input int val_bit);
    return word_width - val_bit;
  endfunction

endpackage

// File: rtl/sync_buffer.sv
// Single-clock FIFO with show-ahead read port; push on full and pop on empty are ignored.
module sync_buffer #(
  parameter int bit_width = 8,
  parameter int addr_len  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [bit_width-1:0] data_in,
  output logic [bit_width-1:0] data_out,
  output logic [addr_len:0]    count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [addr_len:0] depth = {1'b1, {addr_len{1'b0}}};

  logic [bit_width-1:0] mem [0:(1<<addr_len)-1];
  logic [addr_len-1:0]  wr_ptr;
  logic [addr_len-1:0]  rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == depth);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/enh_demux.sv
// Splits one tagged stream round-robin onto two tagged branches, honouring
// per-branch backpressure; words are buffered in a FIFO that reports full upstream.
module enh_demux
  import enh_pkg::*;
#(
  parameter int word_width     = 16,
  parameter int val_bit        = 1,
  parameter int log_buffer_len = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [word_width-1:0]   in,
  output logic                    full,
  input  logic                    full_1,
  input  logic                    full_2,
  output logic [word_width-1:0]   out_1,
  output logic [word_width-1:0]   out_2,
  output logic [log_buffer_len:0] level,
  output logic                    overflow
);

  localparam int pw = payload_width(word_width, val_bit);

  logic [pw-1:0]         head;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  sel_1;
  logic                  sel_2;
  logic [word_width-1:0] popped;
  pref_t                 pref;
  pref_t                 pref_next;

  // A valid word is only admitted when the FIFO has room at the start of the
  // cycle; a concurrent pop does not make room for it.
  assign push = in[word_width-1] && !full;
  assign pop  = sel_1 || sel_2;

  sync_buffer #(
    .bit_width (pw),
    .addr_len  (log_buffer_len)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (in[pw-1:0]),
    .data_out (head),
    .count    (level),
    .full     (full),
    .empty    (fifo_empty)
  );

  // Dispatch: prefer pref's branch, fall back to the other without toggling.
  always_comb begin
    sel_1     = 1'b0;
    sel_2     = 1'b0;
    pref_next = pref;
    if (!fifo_empty) begin
      if (pref == LEFT) begin
        if (!full_1) begin
          sel_1     = 1'b1;
          pref_next = RIGHT;
        end else if (!full_2) begin
          sel_2 = 1'b1;
        end
      end else begin
        if (!full_2) begin
          sel_2     = 1'b1;
          pref_next = LEFT;
        end else if (!full_1) begin
          sel_1 = 1'b1;
        end
      end
    end
  end

  // Re-tag the head payload: valid MSB, remaining validity bits zero.
  always_comb begin
    popped                 = '0;
    popped[word_width-1]   = 1'b1;
    popped[pw-1:0]         = head;
  end

  // Branch preference register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pref <= LEFT;
    else     pref <= pref_next;
  end

  // Registered outputs: one-cycle valid pulse on the chosen branch, zeros otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_1 <= '0;
      out_2 <= '0;
    end else begin
      out_1 <= sel_1 ? popped : '0;
      out_2 <= sel_2 ? popped : '0;
    end
  end

  // Sticky record of any valid word refused because the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overflow <= 1'b0;
    else if (in[word_width-1] && full)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_enh_demux.sv
// Scoreboard bench for enh_demux: expected (branch, word) pairs are queued as
// stimulus is driven and retired by a monitor as words leave the DUT.
module tb_enh_demux;

  typedef struct packed {
    logic        br;
    logic [15:0] w;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        full;
  logic        full_1;
  logic        full_2;
  logic [15:0] out_1;
  logic [15:0] out_2;
  logic [3:0]  level;
  logic        overflow;

  int   vectors;
  int   miscompares;
  bit   mon_en;
  exp_t exp_q[$];

  enh_demux #(
    .word_width     (16),
    .val_bit        (1),
    .log_buffer_len (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .full     (full),
    .full_1   (full_1),
    .full_2   (full_2),
    .out_1    (out_1),
    .out_2    (out_2),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid output word retires the queue head; idle outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (out_1[15] && out_2[15]) begin
        vectors++;
        miscompares++;
        $display("FAIL dual_valid: out_1=%h out_2=%h, required at most one valid", out_1, out_2);
      end
      if (out_1[15]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out_1: got %h, required no word", out_1);
        end else begin
          e = exp_q.pop_front();
          if (e.br !== 1'b0 || e.w !== out_1) begin
            miscompares++;
            $display("FAIL word_out_1: got branch 1 word %h, required branch %0d word %h",
                     out_1, e.br + 1, e.w);
          end
        end
      end else begin
        vectors++;
        if (out_1 !== 16'h0000) begin
          miscompares++;
          $display("FAIL idle_out_1: got %h, required 0000", out_1);
        end
      end
      if (out_2[15]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out_2: got %h, required no word", out_2);
        end else begin
          e = exp_q.pop_front();
          if (e.br !== 1'b1 || e.w !== out_2) begin
            miscompares++;
            $display("FAIL word_out_2: got branch 2 word %h, required branch %0d word %h",
                     out_2, e.br + 1, e.w);
          end
        end
      end else begin
        vectors++;
        if (out_2 !== 16'h0000) begin
          miscompares++;
          $display("FAIL idle_out_2: got %h, required 0000", out_2);
        end
      end
    end
  end

  task automatic expect_word(input logic br, input logic [15:0] w);
    exp_t e;
    e.br = br;
    e.w  = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    din    = 16'h0000;
    full_1 = 1'b0;
    full_2 = 1'b0;
    rst    = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_out_1: got %h, required 0000", out_1);
    end
    vectors++;
    if (out_2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_out_2: got %h, required 0000", out_2);
    end
    vectors++;
    if (level !== 4'd0 || full !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got level=%0d full=%b overflow=%b, required 0 0 0",
               level, full, overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_round_robin;
    bit ok;
    full_1 = 1'b0;
    full_2 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      din = 16'h8001 + 16'(i);
      expect_word(i[0], din);
      @(posedge clk);
      #1;
      if (i == 1) begin
        vectors++;
        if (out_1 !== 16'h8001) begin
          miscompares++;
          $display("FAIL first_latency: out_1=%h one edge after push, required 8001", out_1);
        end
      end
    end
    din = 16'h0000;
    wait_empty(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rr_drain: %0d words outstanding, required 0", exp_q.size());
    end
    vectors++;
    if (level !== 4'd0) begin
      miscompares++;
      $display("FAIL rr_level: got %0d, required 0", level);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    @(posedge clk);
    #1;
    full_2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 16'h8010 + 16'(i);
      expect_word(1'b0, din);
      @(posedge clk);
      #1;
    end
    din = 16'h0000;
    wait_empty(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_drain: %0d words outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
    full_2 = 1'b0;
    din    = 16'h8014;
    expect_word(1'b1, din);
    @(posedge clk);
    #1;
    din = 16'h0000;
    wait_empty(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_pref_kept: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow;
    bit ok;
    @(posedge clk);
    #1;
    full_1 = 1'b1;
    full_2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 16'h8020 + 16'(i);
      if (i < 8) expect_word(i[0], din);
      @(posedge clk);
      #1;
      if (i == 7) begin
        vectors++;
        if (level !== 4'd8 || full !== 1'b1) begin
          miscompares++;
          $display("FAIL fill: got level=%0d full=%b, required 8 1", level, full);
        end
      end
    end
    din = 16'h0000;
    vectors++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow_set: got overflow=%b level=%0d, required 1 8", overflow, level);
    end
    full_1 = 1'b0;
    full_2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (level !== 4'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_level: got level=%0d full=%b after 8 cycles, required 0 0", level, full);
    end
    wait_empty(4, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain_words: %0d words outstanding, required 0", exp_q.size());
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_invalid;
    @(posedge clk);
    #1;
    din = 16'h7FFF;
    @(posedge clk);
    #1;
    din = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (level !== 4'd0) begin
      miscompares++;
      $display("FAIL invalid_level: got %0d, required 0", level);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(posedge clk);
    #1;
    full_1 = 1'b1;
    full_2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 16'h8060 + 16'(i);
      if (i < 2) expect_word(i[0], din);
      @(posedge clk);
      #1;
    end
    din    = 16'h0000;
    full_1 = 1'b0;
    full_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (level !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_level: got %0d, required 5", level);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (level !== 4'd0 || out_1 !== 16'h0000 || out_2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset: got level=%0d out_1=%h out_2=%h, required 0 0000 0000",
               level, out_1, out_2);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_pre_reset_words: %0d words outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    din = 16'h8055;
    expect_word(1'b0, din);
    @(posedge clk);
    #1;
    din = 16'h0000;
    wait_empty(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL post_reset_word: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_invalid();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d words outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
